// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU core. Instructions are {op[2:0], addr} words
// fetched from a combinational instruction port. Data memory is accessed
// over a req/ack handshake that may insert any number of wait states.
module acc_cpu_core #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                clk,
   input  logic                R,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [ADDR_W+2:0]   imem_data,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0]   dmem_wdata,
   input  logic [DATA_W-1:0]   dmem_rdata,
   input  logic                dmem_ack,
   output logic [DATA_W-1:0]   ac,
   output logic [ADDR_W-1:0]   pc,
   output logic                carry,
   output logic                zero,
   output logic                halted,
   output logic [1:0]          state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEM    = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      OP_LDA = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_STA = 3'd5,
      OP_JZ  = 3'd6,
      OP_HLT = 3'd7
   } op_e;

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ac_q, ac_d;
   logic                carry_q, carry_d;
   logic [ADDR_W+2:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;

   op_e                 op;
   logic [ADDR_W-1:0]   ir_addr;
   logic [DATA_W:0]     add_res;
   logic                ac_is_zero;

   assign op         = op_e'(ir_q[ADDR_W+2:ADDR_W]);
   assign ir_addr    = ir_q[ADDR_W-1:0];
   assign add_res    = {1'b0, ac_q} + {1'b0, mdr_q};
   assign ac_is_zero = (ac_q == '0);

   // Next-state, datapath updates and memory handshake decode
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ac_d     = ac_q;
      carry_d  = carry_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_d    = imem_data;
            pc_d    = pc_q + 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (op == OP_HLT) begin
               state_d = S_HALT;
            end else if (op == OP_JZ) begin
               if (ac_is_zero) pc_d = ir_addr;
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_STA);
            if (dmem_ack) begin
               if (op == OP_STA) begin
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = dmem_rdata;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            case (op)
               OP_LDA: ac_d = mdr_q;
               OP_ADD: {carry_d, ac_d} = add_res;
               OP_SUB: begin
                  ac_d    = ac_q - mdr_q;
                  carry_d = (ac_q >= mdr_q);
               end
               OP_AND: ac_d = ac_q & mdr_q;
               OP_XOR: ac_d = ac_q ^ mdr_q;
               default: ;
            endcase
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // State and architectural registers; R abandons any pending access
   always_ff @(posedge clk) begin
      if (R) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC_V;
         ac_q    <= '0;
         carry_q <= 1'b0;
         ir_q    <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ac_q    <= ac_d;
         carry_q <= carry_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
      end
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = ir_addr;
   assign dmem_wdata = ac_q;
   assign ac         = ac_q;
   assign pc         = pc_q;
   assign carry      = carry_q;
   assign zero       = ac_is_zero;
   assign halted     = (state_q == S_HALT);
   // HALT has no code of its own on the 2-bit debug port; it reads as EXEC
   assign state      = (state_q == S_HALT) ? 2'd3 : state_q[1:0];

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: program ROM and data RAM models,
// a wait-state capable memory responder, and a write scoreboard.
module tb_acc_cpu_core;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 5;
   localparam int unsigned IW = AW + 3;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          R;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;
   logic [DW-1:0] ac;
   logic [AW-1:0] pc;
   logic          carry;
   logic          zero;
   logic          halted;
   logic [1:0]    state;

   always #5 clk = ~clk;

   acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
      .clk(clk), .R(R),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .ac(ac), .pc(pc), .carry(carry), .zero(zero),
      .halted(halted), .state(state)
   );

   logic [IW-1:0] imem [0:DEPTH-1];
   logic [DW-1:0] dmem [0:DEPTH-1];
   assign imem_data = imem[imem_addr];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t sb_q[$];

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic          resp_en;
   int unsigned   ack_wait;
   int unsigned   wait_cnt;
   logic          man_ack;
   logic [DW-1:0] man_rdata;
   int unsigned   wr_req_cycles;
   int unsigned   wr_count;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input logic [2:0] op, input int unsigned a);
      return {op, AW'(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < int'(DEPTH); i++) imem[i] = ins(3'd7, 0);
   endtask

   task automatic do_reset();
      R = 1'b1;
      step();
      step();
      R = 1'b0;
   endtask

   task automatic run_to_halt(input string tag, output int unsigned cyc);
      cyc = 0;
      while (!halted && cyc < 300) begin
         step();
         cyc++;
      end
      check_eq({tag, "_halt_reached"}, 32'(halted), 32'd1);
   endtask

   task automatic push_wr(input int unsigned a, input logic [DW-1:0] d);
      wr_t w;
      w.addr = AW'(a);
      w.data = d;
      sb_q.push_back(w);
   endtask

   // Data memory responder: acks after ack_wait wait cycles, checks and retires writes
   initial begin
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      wait_cnt   = 0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            dmem_ack   = man_ack;
            dmem_rdata = man_rdata;
            wait_cnt   = 0;
         end else if (dmem_req) begin
            if (dmem_we) begin
               wr_req_cycles++;
               check_eq("wr_pending", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  check_eq("wr_addr", 32'(dmem_addr), 32'(sb_q[0].addr));
                  check_eq("wr_data", 32'(dmem_wdata), 32'(sb_q[0].data));
               end
            end
            if (wait_cnt == ack_wait) begin
               dmem_ack = 1'b1;
               wait_cnt = 0;
               if (dmem_we) begin
                  dmem[dmem_addr] = dmem_wdata;
                  wr_count++;
                  if (sb_q.size() != 0) void'(sb_q.pop_front());
               end else begin
                  dmem_rdata = dmem[dmem_addr];
               end
            end else begin
               dmem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            dmem_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   initial begin
      int unsigned cyc;
      logic        req_seen;
      R = 1'b1;
      resp_en = 1'b1;
      ack_wait = 0;
      man_ack = 1'b0;
      man_rdata = '0;
      wr_req_cycles = 0;
      wr_count = 0;
      for (int i = 0; i < int'(DEPTH); i++) dmem[i] = '0;
      clear_imem();

      // LDA/ADD overflow to zero, then HLT freeze
      dmem[21] = 8'h01;
      dmem[1]  = 8'hFF;
      imem[0] = ins(3'd0, 21);
      imem[1] = ins(3'd1, 1);
      imem[2] = ins(3'd7, 0);
      step();
      do_reset();
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_ac", 32'(ac), 32'd0);
      check_eq("rst_carry", 32'(carry), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_req", 32'(dmem_req), 32'd0);
      run_to_halt("add", cyc);
      check_eq("add_cycles", 32'(cyc), 32'd10);
      check_eq("add_ac", 32'(ac), 32'h00);
      check_eq("add_carry", 32'(carry), 32'd1);
      check_eq("add_zero", 32'(zero), 32'd1);
      check_eq("add_state", 32'(state), 32'd3);
      check_eq("add_pc", 32'(pc), 32'd3);
      req_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         req_seen = req_seen | dmem_req;
      end
      check_eq("hlt_pc", 32'(pc), 32'd3);
      check_eq("hlt_ac", 32'(ac), 32'h00);
      check_eq("hlt_carry", 32'(carry), 32'd1);
      check_eq("hlt_halted", 32'(halted), 32'd1);
      check_eq("hlt_req", 32'(req_seen), 32'd0);

      // SUB with borrow, then SUB to zero with no borrow
      dmem[2] = 8'h05;
      dmem[3] = 8'h07;
      clear_imem();
      imem[0] = ins(3'd0, 2);
      imem[1] = ins(3'd2, 3);
      do_reset();
      run_to_halt("sub1", cyc);
      check_eq("sub1_ac", 32'(ac), 32'hFE);
      check_eq("sub1_carry", 32'(carry), 32'd0);
      check_eq("sub1_zero", 32'(zero), 32'd0);
      imem[0] = ins(3'd0, 3);
      imem[1] = ins(3'd2, 3);
      do_reset();
      run_to_halt("sub2", cyc);
      check_eq("sub2_ac", 32'(ac), 32'h00);
      check_eq("sub2_carry", 32'(carry), 32'd1);

      // STA with 3 wait states on every access
      dmem[5] = 8'h5A;
      clear_imem();
      imem[0] = ins(3'd0, 5);
      imem[1] = ins(3'd5, 3);
      ack_wait = 3;
      wr_req_cycles = 0;
      wr_count = 0;
      push_wr(3, 8'h5A);
      do_reset();
      run_to_halt("sta", cyc);
      check_eq("sta_cycles", 32'(cyc), 32'd15);
      check_eq("sta_req_cycles", 32'(wr_req_cycles), 32'd4);
      check_eq("sta_writes", 32'(wr_count), 32'd1);
      check_eq("sta_sb_empty", 32'(sb_q.size()), 32'd0);
      ack_wait = 0;

      // AND/XOR leave carry alone; STA result through the scoreboard
      dmem[1] = 8'hFF;
      dmem[6] = 8'hF0;
      dmem[7] = 8'h3C;
      clear_imem();
      imem[0] = ins(3'd0, 1);
      imem[1] = ins(3'd1, 1);
      imem[2] = ins(3'd3, 7);
      imem[3] = ins(3'd4, 6);
      imem[4] = ins(3'd5, 8);
      imem[5] = ins(3'd0, 6);
      push_wr(8, 8'hCC);
      do_reset();
      run_to_halt("logic", cyc);
      check_eq("logic_ac", 32'(ac), 32'hF0);
      check_eq("logic_carry", 32'(carry), 32'd1);
      check_eq("logic_sb_empty", 32'(sb_q.size()), 32'd0);

      // JZ taken with ac=0, not taken with ac!=0
      clear_imem();
      imem[0]  = ins(3'd6, 9);
      imem[9]  = ins(3'd0, 5);
      imem[10] = ins(3'd6, 20);
      do_reset();
      run_to_halt("jz", cyc);
      check_eq("jz_cycles", 32'(cyc), 32'd10);
      check_eq("jz_pc", 32'(pc), 32'd12);
      check_eq("jz_ac", 32'(ac), 32'h5A);

      // PC wraps from all-ones to zero
      clear_imem();
      imem[0]  = ins(3'd6, 31);
      imem[31] = ins(3'd0, 5);
      do_reset();
      step();
      step();
      check_eq("wrap_pc31", 32'(pc), 32'd31);
      step();
      check_eq("wrap_pc0", 32'(pc), 32'd0);
      run_to_halt("wrap", cyc);
      check_eq("wrap_pc_end", 32'(pc), 32'd2);
      check_eq("wrap_ac", 32'(ac), 32'h5A);

      // Reset held mid-MEM; a late ack must not complete anything
      dmem[20] = 8'h33;
      dmem[21] = 8'h44;
      clear_imem();
      imem[0] = ins(3'd0, 20);
      imem[1] = ins(3'd0, 21);
      do_reset();
      repeat (4) step();
      check_eq("mr_ac_pre", 32'(ac), 32'h33);
      resp_en = 1'b0;
      man_ack = 1'b0;
      step();
      step();
      check_eq("mr_req_pre", 32'(dmem_req), 32'd1);
      check_eq("mr_state_pre", 32'(state), 32'd2);
      R = 1'b1;
      step();
      check_eq("mr_req_next", 32'(dmem_req), 32'd0);
      step();
      R = 1'b0;
      check_eq("mr_pc", 32'(pc), 32'd0);
      check_eq("mr_ac", 32'(ac), 32'h00);
      check_eq("mr_carry", 32'(carry), 32'd0);
      check_eq("mr_state", 32'(state), 32'd0);
      man_ack = 1'b1;
      man_rdata = 8'h77;
      step();
      man_ack = 1'b0;
      check_eq("late_ack_ac", 32'(ac), 32'h00);
      check_eq("late_ack_state", 32'(state), 32'd1);
      step();
      resp_en = 1'b1;
      run_to_halt("mr", cyc);
      check_eq("mr_ac_end", 32'(ac), 32'h44);
      check_eq("mr_pc_end", 32'(pc), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
